// File: rtl/rob_flush_sequencer_pkg.sv
// rob_flush_sequencer_pkg: shared constants, tag type and FSM encoding for the ROB flush sequencer.
package rob_flush_sequencer_pkg;
    localparam int N_ROB = 32;
    localparam int N_WAY = 3;
    localparam int CDB_BITS = 6;
    localparam int CNT_BITS = $clog2(N_ROB) + 1;

    typedef logic [CDB_BITS-1:0] tag_t;

    localparam tag_t ZERO_REG_PR = '0;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} fsm_e;

    function automatic logic [CNT_BITS-1:0] popcount(input logic [N_ROB-1:0] v);
        popcount = '0;
        for (int i = 0; i < N_ROB; i++) popcount += CNT_BITS'(v[i]);
    endfunction
endpackage

// File: rtl/rob_flush_sequencer_if.sv
// rob_flush_sequencer_if: ROB capture, free-list return and dispatch status signals of the flush sequencer.
interface rob_flush_sequencer_if;
    import rob_flush_sequencer_pkg::*;

    logic                      flush_req;
    logic [N_ROB*CDB_BITS-1:0] flush_tags;
    logic                      free_ready;
    logic [N_WAY-1:0]          free_valid;
    logic [N_WAY*CDB_BITS-1:0] free_tag;
    logic                      dispatch_stall;
    logic                      busy;
    logic [CNT_BITS-1:0]       pending_cnt;
    logic                      flush_done;
    logic                      flush_overrun;

    modport master (
        output flush_req, flush_tags, free_ready,
        input  free_valid, free_tag, dispatch_stall, busy, pending_cnt, flush_done, flush_overrun
    );

    modport slave (
        input  flush_req, flush_tags, free_ready,
        output free_valid, free_tag, dispatch_stall, busy, pending_cnt, flush_done, flush_overrun
    );
endinterface

// File: rtl/rob_flush_sequencer_lowest_n_picker.sv
// lowest_n_picker: one-hot grants for the N_WAY lowest set bits of a valid vector, lane 0 = lowest.
module lowest_n_picker #(
    parameter int N_ROB = 32,
    parameter int N_WAY = 3
) (
    input  logic [N_ROB-1:0]            valid,
    output logic [N_WAY-1:0][N_ROB-1:0] grant,
    output logic [N_WAY-1:0]            hit
);
    logic [N_WAY-1:0][N_ROB-1:0] rem;

    assign rem[0] = valid;

    for (genvar w = 0; w < N_WAY; w++) begin : g_lane
        // x & -x isolates the lowest set bit
        assign grant[w] = rem[w] & (-rem[w]);
        assign hit[w] = |rem[w];
        if (w < N_WAY - 1) begin : g_next
            assign rem[w+1] = rem[w] & ~grant[w];
        end
    end
endmodule

// File: rtl/rob_flush_sequencer.sv
// rob_flush_sequencer: captures a ROB flush tag vector and drains it to the free list N_WAY tags per cycle.
module rob_flush_sequencer
    import rob_flush_sequencer_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    rob_flush_sequencer_if.slave  fs
);
    fsm_e                        state_q, state_d;
    logic [N_ROB-1:0]            valid_q, valid_d, cap_valid, clr;
    tag_t [N_ROB-1:0]            tag_q;
    tag_t [N_WAY-1:0]            lane_tag;
    logic [CNT_BITS-1:0]         cnt_q;
    logic                        overrun_q;
    logic [N_WAY-1:0][N_ROB-1:0] grant;
    logic [N_WAY-1:0]            hit;
    logic                        capture, busy, draining;

    lowest_n_picker #(.N_ROB(N_ROB), .N_WAY(N_WAY)) u_picker (
        .valid (valid_q),
        .grant (grant),
        .hit   (hit)
    );

    always_comb begin
        for (int i = 0; i < N_ROB; i++)
            cap_valid[i] = fs.flush_tags[i*CDB_BITS +: CDB_BITS] != '0 &&
                           fs.flush_tags[i*CDB_BITS +: CDB_BITS] != ZERO_REG_PR;
    end

    always_comb begin
        clr = '0;
        for (int w = 0; w < N_WAY; w++) clr |= grant[w];
    end

    always_comb begin
        lane_tag = '0;
        for (int w = 0; w < N_WAY; w++)
            for (int i = 0; i < N_ROB; i++)
                lane_tag[w] |= grant[w][i] ? tag_q[i] : '0;
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        capture = 1'b0;
        case (state_q)
            IDLE: if (fs.flush_req) begin
                capture = 1'b1;
                valid_d = cap_valid;
                state_d = |cap_valid ? DRAIN : DONE;
            end
            DRAIN: if (fs.free_ready) begin
                valid_d = valid_q & ~clr;
                state_d = |(valid_q & ~clr) ? DRAIN : DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cnt_q   <= popcount(valid_d);
            if (capture) tag_q <= fs.flush_tags;
            // a request while busy leaves the buffer alone; only the sticky flag records it
            if (busy && fs.flush_req) overrun_q <= 1'b1;
        end
    end

    assign busy              = state_q != IDLE;
    assign draining          = state_q == DRAIN;
    assign fs.busy           = busy;
    assign fs.dispatch_stall = fs.flush_req | busy;
    assign fs.flush_done     = state_q == DONE;
    assign fs.pending_cnt    = cnt_q;
    assign fs.flush_overrun  = overrun_q;
    assign fs.free_valid     = draining ? hit : '0;
    assign fs.free_tag       = draining ? lane_tag : '0;
endmodule

// File: tb/tb_rob_flush_sequencer.sv
// tb_rob_flush_sequencer: scoreboard bench for the flush sequencer; groups are predicted at capture and popped per transfer.
module tb_rob_flush_sequencer;
    import rob_flush_sequencer_pkg::*;

    localparam int TW = N_ROB * CDB_BITS;
    localparam int LW = N_WAY * CDB_BITS;

    typedef struct packed {
        logic [N_WAY-1:0] v;
        logic [LW-1:0]    t;
    } grp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    grp_t sb[$];
    logic [TW-1:0] t7, t32, talt, trnd;

    rob_flush_sequencer_if fs();

    rob_flush_sequencer dut (
        .clock (clock),
        .reset (reset),
        .fs    (fs)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_model(input logic [TW-1:0] tags, output int cnt);
        grp_t g;
        int   lane;
        tag_t t;
        g = '0;
        lane = 0;
        cnt = 0;
        for (int i = 0; i < N_ROB; i++) begin
            t = tags[i*CDB_BITS +: CDB_BITS];
            if (t != 0 && t != ZERO_REG_PR) begin
                g.v[lane] = 1'b1;
                g.t[lane*CDB_BITS +: CDB_BITS] = t;
                lane++;
                cnt++;
                if (lane == N_WAY) begin
                    sb.push_back(g);
                    g = '0;
                    lane = 0;
                end
            end
        end
        if (lane != 0) sb.push_back(g);
    endtask

    task automatic do_flush(input string nm, input logic [TW-1:0] tags, input int hold_lo, input int hold_hi,
                            input int pulse_c, input logic [TW-1:0] alt, input int abort_cnt);
        int   cnt;
        bit   done;
        grp_t g;
        @(posedge clock); #1;
        fs.flush_req = 1'b1;
        fs.flush_tags = tags;
        fs.free_ready = 1'b1;
        push_model(tags, cnt);
        @(negedge clock);
        check({nm, ".c0_stall"}, 64'(fs.dispatch_stall), 64'(1));
        check({nm, ".c0_busy"}, 64'(fs.busy), 64'(0));
        check({nm, ".c0_pending"}, 64'(fs.pending_cnt), 64'(0));
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clock); #1;
            if (cnt == abort_cnt) begin
                check({nm, ".pre_rst_pending"}, 64'(fs.pending_cnt), 64'(cnt));
                fs.flush_req = 1'b0;
                reset = 1'b0;
                #1;
                check({nm, ".rst_valid"}, 64'(fs.free_valid), 64'(0));
                check({nm, ".rst_tag"}, 64'(fs.free_tag), 64'(0));
                check({nm, ".rst_busy"}, 64'(fs.busy), 64'(0));
                check({nm, ".rst_pending"}, 64'(fs.pending_cnt), 64'(0));
                check({nm, ".rst_stall"}, 64'(fs.dispatch_stall), 64'(0));
                sb.delete();
                repeat (2) @(posedge clock);
                #1 reset = 1'b1;
                @(negedge clock);
                check({nm, ".post_busy"}, 64'(fs.busy), 64'(0));
                check({nm, ".post_pending"}, 64'(fs.pending_cnt), 64'(0));
                check({nm, ".post_stall"}, 64'(fs.dispatch_stall), 64'(0));
                check({nm, ".post_valid"}, 64'(fs.free_valid), 64'(0));
                return;
            end
            fs.flush_req = (c == pulse_c);
            fs.flush_tags = (c == pulse_c) ? alt : tags;
            fs.free_ready = !(c >= hold_lo && c <= hold_hi);
            @(negedge clock);
            check({nm, ".stall"}, 64'(fs.dispatch_stall), 64'(1));
            check({nm, ".busy"}, 64'(fs.busy), 64'(1));
            if (sb.size() != 0) begin
                g = sb[0];
                check({nm, ".pending"}, 64'(fs.pending_cnt), 64'(cnt));
                check({nm, ".valid"}, 64'(fs.free_valid), 64'(g.v));
                check({nm, ".tag"}, 64'(fs.free_tag), 64'(g.t));
                check({nm, ".done_early"}, 64'(fs.flush_done), 64'(0));
                if (fs.free_ready) begin
                    void'(sb.pop_front());
                    cnt -= $countones(g.v);
                end
            end else begin
                check({nm, ".done"}, 64'(fs.flush_done), 64'(1));
                check({nm, ".done_valid"}, 64'(fs.free_valid), 64'(0));
                check({nm, ".done_pending"}, 64'(fs.pending_cnt), 64'(0));
                done = 1'b1;
            end
        end
        check({nm, ".finished"}, 64'(done), 64'(1));
        @(posedge clock); #1;
        fs.flush_req = 1'b0;
        fs.free_ready = 1'b1;
        @(negedge clock);
        check({nm, ".idle_stall"}, 64'(fs.dispatch_stall), 64'(0));
        check({nm, ".idle_busy"}, 64'(fs.busy), 64'(0));
        check({nm, ".idle_done"}, 64'(fs.flush_done), 64'(0));
    endtask

    initial begin
        fs.flush_req = 1'b0;
        fs.flush_tags = '0;
        fs.free_ready = 1'b0;
        t7 = '0;
        t32 = '0;
        talt = '0;
        trnd = '0;
        for (int i = 0; i < 7; i++) t7[i*CDB_BITS +: CDB_BITS] = tag_t'(i + 1);
        for (int i = 0; i < N_ROB; i++) t32[i*CDB_BITS +: CDB_BITS] = tag_t'(i + 1);
        for (int i = 0; i < 7; i++) talt[i*CDB_BITS +: CDB_BITS] = tag_t'(i + 40);
        for (int i = 0; i < N_ROB; i++)
            trnd[i*CDB_BITS +: CDB_BITS] = ($urandom_range(0, 2) == 0) ? '0 : tag_t'($urandom_range(1, 8));
        repeat (2) @(posedge clock);
        #1;
        check("reset.valid", 64'(fs.free_valid), 64'(0));
        check("reset.busy", 64'(fs.busy), 64'(0));
        check("reset.pending", 64'(fs.pending_cnt), 64'(0));
        check("reset.stall", 64'(fs.dispatch_stall), 64'(0));
        check("reset.done", 64'(fs.flush_done), 64'(0));
        check("reset.overrun", 64'(fs.flush_overrun), 64'(0));
        reset = 1'b1;
        do_flush("seq7", t7, 0, -1, 0, '0, -1);
        do_flush("hold", t7, 2, 3, 0, '0, -1);
        do_flush("zero", '0, 0, -1, 0, '0, -1);
        do_flush("full", t32, 0, -1, 0, '0, -1);
        check("overrun.clear", 64'(fs.flush_overrun), 64'(0));
        do_flush("ovr", t7, 0, -1, 1, talt, -1);
        check("overrun.set", 64'(fs.flush_overrun), 64'(1));
        do_flush("rnd", trnd, 2, 2, 0, '0, -1);
        check("overrun.sticky", 64'(fs.flush_overrun), 64'(1));
        do_flush("rst", t32, 0, -1, 0, '0, 5);
        check("overrun.reset", 64'(fs.flush_overrun), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
